// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-bit pad input conditioning (2-flop sync, counter debounce, edge pulses)
//
// Ports:
//    clk        - system clock
//    reset_     - asynchronous active-low reset
//    pad_di     - raw asynchronous pad levels
//    di         - synchronized, debounced levels
//    rise_pulse - one-cycle pulse when a di bit goes 0->1
//    fall_pulse - one-cycle pulse when a di bit goes 1->0
//    edge_clr   - write-1-to-clear strobe for edge_pend
//    edge_pend  - sticky edge-seen flags
//    irq        - OR of edge_pend
//
// Build option: define GPIO_IN_EDGE_IRQ_EN to add the sticky edge_pend flops
// and irq; otherwise edge_pend/irq are constant 0 and edge_clr is ignored.
module gpio_in_filter #(
   parameter int NR_GPIOS        = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset_,
   input  logic [NR_GPIOS-1:0] pad_di,
   output logic [NR_GPIOS-1:0] di,
   output logic [NR_GPIOS-1:0] rise_pulse,
   output logic [NR_GPIOS-1:0] fall_pulse,
   input  logic [NR_GPIOS-1:0] edge_clr,
   output logic [NR_GPIOS-1:0] edge_pend,
   output logic                irq
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [NR_GPIOS-1:0] sync1_q, sync2_q, di_q, di_d, rise_q, rise_d, fall_q, fall_d;
   logic [CW-1:0]       cnt_q [NR_GPIOS];
   logic [CW-1:0]       cnt_d [NR_GPIOS];
   // The count only advances while sync2 disagrees with di, so reaching LAST
   // implies a run of mismatches; on a match sync2 equals di anyway.
   always_comb begin
      for (int i = 0; i < NR_GPIOS; i++) begin
         cnt_d[i] = (sync2_q[i] == di_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
         di_d[i]  = (cnt_q[i] == LAST) ? sync2_q[i] : di_q[i];
      end
   end
   assign rise_d = di_d & ~di_q;
   assign fall_d = ~di_d & di_q;
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         sync1_q <= '0;
         sync2_q <= '0;
         di_q    <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         cnt_q   <= '{default: '0};
      end else begin
         sync1_q <= pad_di;
         sync2_q <= sync1_q;
         di_q    <= di_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end
   assign di         = di_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
`ifdef GPIO_IN_EDGE_IRQ_EN
   logic [NR_GPIOS-1:0] edge_pend_q, edge_pend_d;
   logic                irq_q;
   // The pending bit rises together with the pulse (rise_d/fall_d) and a
   // clear landing in the cycle the pulse is visible (rise_q/fall_q) loses.
   assign edge_pend_d = (edge_pend_q & ~edge_clr) | rise_d | fall_d | rise_q | fall_q;
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         edge_pend_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         edge_pend_q <= edge_pend_d;
         irq_q       <= |edge_pend_d;
      end
   end
   assign edge_pend = edge_pend_q;
   assign irq       = irq_q;
`else
   logic unused_edge_clr;
   assign unused_edge_clr = ^edge_clr;
   assign edge_pend       = '0;
   assign irq             = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: randomized and directed check of gpio_in_filter against a window-based reference model
module tb_gpio_in_filter;
   localparam int D = 16;
   logic       clk = 1'b0;
   logic       reset_ = 1'b0;
   logic [7:0] pad_di = '0, edge_clr = '0;
   logic [7:0] di, rise_pulse, fall_pulse, edge_pend;
   logic       irq;
   int         vecs = 0, errs = 0;
   // reference model: a bit of di flips once the last D synchronized samples
   // all disagree with it
   logic [7:0] s1_m, s2_m, di_m, rise_m, fall_m, pend_m;
   logic       irq_m;
   logic [7:0] win[$];

   gpio_in_filter #(.NR_GPIOS(8), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .reset_(reset_), .pad_di(pad_di), .di(di),
      .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .edge_clr(edge_clr), .edge_pend(edge_pend), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      s1_m = '0; s2_m = '0; di_m = '0; rise_m = '0; fall_m = '0; pend_m = '0; irq_m = 1'b0;
      win = {};
      for (int i = 0; i < D; i++) win.push_back(8'h00);
   endtask

   task automatic model_edge(input logic [7:0] p, input logic [7:0] c);
      logic [7:0] seen, mism, nd, prev;
      seen = s2_m; s2_m = s1_m; s1_m = p;
      win.push_back(seen);
      if (win.size() > D) void'(win.pop_front());
      mism = 8'hFF;
      foreach (win[i]) mism &= win[i] ^ di_m;
      nd = di_m ^ mism;
      prev = rise_m | fall_m;
      rise_m = nd & ~di_m;
      fall_m = ~nd & di_m;
      di_m = nd;
      pend_m = (pend_m & ~c) | rise_m | fall_m | prev;
      irq_m = |pend_m;
   endtask

   task automatic check_all();
      chk("di", di, di_m);
      chk("rise", rise_pulse, rise_m);
      chk("fall", fall_pulse, fall_m);
`ifdef GPIO_IN_EDGE_IRQ_EN
      chk("pend", edge_pend, pend_m);
      chk("irq", {7'd0, irq}, {7'd0, irq_m});
`else
      chk("pend_off", edge_pend, 8'h00);
      chk("irq_off", {7'd0, irq}, 8'h00);
`endif
   endtask

   task automatic tick(input logic [7:0] p, input logic [7:0] c);
      pad_di = p; edge_clr = c;
      @(posedge clk);
      if (!reset_) model_reset(); else model_edge(p, c);
      #1 check_all();
   endtask

   task automatic run(input logic [7:0] p, input int n);
      for (int i = 0; i < n; i++) tick(p, 8'h00);
   endtask

   initial begin
      int         n;
      logic       seen;
      logic [7:0] p;
      model_reset();
      // reset hold with pads high
      run(8'hFF, 4);
      reset_ = 1'b1;
      n = 0;
      for (int i = 1; i <= 40 && n == 0; i++) begin
         tick(8'hFF, 8'h00);
         if (di == 8'hFF) begin
            n = i;
            chk("reset_rise_all", rise_pulse, 8'hFF);
         end
      end
      chk("reset_latency", 8'(n), 8'd18);
      run(8'hFF, 3);
      tick(8'h00, 8'hFF);
      run(8'h00, 22);
      // glitch 15 cycles rejected, 16 accepted
      run(8'h08, 15);
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick(8'h00, 8'h00);
         seen |= rise_pulse[3] | di[3];
      end
      chk("glitch15", {7'd0, seen}, 8'h00);
      run(8'h08, 16);
      n = 0;
      for (int i = 0; i < 25; i++) begin
         tick(8'h00, 8'h00);
         n += int'(rise_pulse[3]);
      end
      chk("glitch16_pulses", 8'(n), 8'd1);
      run(8'h00, 22);
      // fall timing on bit 5
      run(8'h20, 22);
      n = 0;
      for (int i = 0; i <= 30 && n == 0; i++) begin
         tick(8'h00, 8'h00);
         if (fall_pulse[5]) n = i;
      end
      chk("fall5_edge", 8'(n), 8'd17);
      tick(8'h00, 8'h00);
      chk("fall5_width", fall_pulse, 8'h00);
      // reset in the middle of a second fall
      run(8'h20, 22);
      run(8'h00, 10);
      #2 reset_ = 1'b0;
      model_reset();
      #1 check_all();
      run(8'h00, 3);
      reset_ = 1'b1;
      run(8'h00, 22);
      // multi-bit simultaneity
      run(8'h0F, 22);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick(8'hF0, 8'h00);
         if (rise_pulse != 8'h00 || fall_pulse != 8'h00) begin
            seen = 1'b1;
            chk("multi_rise", rise_pulse, 8'hF0);
            chk("multi_fall", fall_pulse, 8'h0F);
         end
      end
      chk("multi_seen", {7'd0, seen}, 8'h01);
      run(8'hF0, 5);
      // sticky pending and clear
      tick(8'h00, 8'hFF);
      run(8'h00, 22);
      tick(8'h00, 8'hFF);
      tick(8'h00, 8'hFF);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick(8'h04, 8'h00);
         seen = rise_pulse[2];
      end
      chk("irq_rise_seen", {7'd0, seen}, 8'h01);
      run(8'h04, 2);
      tick(8'h04, 8'h04);
      run(8'h00, 22);
      tick(8'h00, 8'h04);
      tick(8'h00, 8'h04);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick(8'h04, 8'h00);
         seen = rise_pulse[2];
      end
      tick(8'h04, 8'h04);
`ifdef GPIO_IN_EDGE_IRQ_EN
      chk("clr_vs_set", edge_pend, 8'h04);
`else
      chk("clr_vs_set", edge_pend, 8'h00);
`endif
      tick(8'h04, 8'h04);
      run(8'h04, 3);
      // randomized: alternate glitchy and slow segments
      p = 8'h00;
      for (int s = 0; s < 24; s++) begin
         int rate = (s % 2 == 0) ? 6 : 60;
         for (int i = 0; i < 80; i++) begin
            for (int b = 0; b < 8; b++)
               if ($urandom_range(rate - 1) == 0) p[b] = ~p[b];
            tick(p, ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00);
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
